addr_seq: RTL and testbench

Effective-address sequencer for the 6502 core. On `start`, it walks the operand bytes of one addressing mode: it advances PC, loads the T register, and requests a high-byte increment on T when an index add crosses a page. It drives the control inputs of the 16-bit PC/T register pair and the address-bus source select. It sits between the instruction decoder, which issues `start`/`mode`, and the PC and T register instances.

---
 rtl/addr_seq.sv | 213 +++++++++++++++++++++
 tb/tb_addr_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : addr_seq
// Description : Effective-address sequencer for the 6502 core. Walks the
//               operand bytes of one addressing mode, drives the PC/T
//               register-pair strobes and the address-bus source select.
// Config      : ADDR_SEQ_STORE_FIXUP_EN - indexed stores always take the
//               FIXUP cycle (NMOS cycle counts).
// Revision    : 1.0 - initial release
// ============================================================================
module addr_seq #(
  parameter logic [7:0] ZP_PAGE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       is_store,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [7:0] data_in,
  output logic       pc_inc,
  output logic       t_load_l,
  output logic       t_load_h,
  output logic       t_h_inc,
  output logic [7:0] t_l_in,
  output logic [7:0] t_h_in,
  output logic [1:0] addr_sel,
  output logic [7:0] ptr_out,
  output logic       busy,
  output logic       done,
  output logic       page_cross
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPLO  = 3'd1,
    S_OPHI  = 3'd2,
    S_PLO   = 3'd3,
    S_PHI   = 3'd4,
    S_FIXUP = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [2:0] c_M_ZP   = 3'd0;
  localparam logic [2:0] c_M_ZPX  = 3'd1;
  localparam logic [2:0] c_M_ZPY  = 3'd2;
  localparam logic [2:0] c_M_ABS  = 3'd3;
  localparam logic [2:0] c_M_ABSX = 3'd4;
  localparam logic [2:0] c_M_ABSY = 3'd5;
  localparam logic [2:0] c_M_INDY = 3'd6;
  localparam logic [2:0] c_M_RSVD = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       pcross_q, pcross_d;

  logic       w_pc_inc, w_t_load_l, w_t_load_h, w_t_h_inc, w_done;
  logic [7:0] w_t_l_in, w_t_h_in;
  logic [1:0] w_addr_sel;
  logic [8:0] w_sum;
  logic       w_store_fix;

  // Operand/pointer low byte plus captured index, carry kept in bit 8
  assign w_sum = {1'b0, data_in} + {1'b0, idx_q};

`ifdef ADDR_SEQ_STORE_FIXUP_EN
  logic store_q, store_d;

  // Indexed stores always spend the fix-up cycle; plain ABS never does
  assign w_store_fix = store_q && (mode_q != c_M_ABS);

  // Store flag register, captured with an accepted start
  always_ff @(posedge clk) begin
    if (rst) store_q <= 1'b0;
    else     store_q <= store_d;
  end

  // Store flag next value
  always_comb begin
    store_d = store_q;
    if (state_q == S_IDLE && start && mode != c_M_RSVD) store_d = is_store;
  end
`else
  logic unused_store;

  assign unused_store = is_store;
  assign w_store_fix  = 1'b0;
`endif

  // Sequencer state and captured operands
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 3'd0;
      idx_q    <= 8'h00;
      ptr_q    <= 8'h00;
      pcross_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      pcross_q <= pcross_d;
    end
  end

  // Next-state and control decode from state and captured mode
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    pcross_d   = pcross_q;
    w_pc_inc   = 1'b0;
    w_t_load_l = 1'b0;
    w_t_load_h = 1'b0;
    w_t_h_inc  = 1'b0;
    w_t_l_in   = 8'h00;
    w_t_h_in   = 8'h00;
    w_addr_sel = 2'd0;
    w_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && mode != c_M_RSVD) begin
          mode_d   = mode;
          pcross_d = 1'b0;
          state_d  = S_OPLO;
          case (mode)
            c_M_ZPX, c_M_ABSX:           idx_d = x_in;
            c_M_ZPY, c_M_ABSY, c_M_INDY: idx_d = y_in;
            default:                     idx_d = 8'h00;
          endcase
        end
      end
      S_OPLO: begin
        w_pc_inc = 1'b1;
        case (mode_q)
          c_M_ZP, c_M_ZPX, c_M_ZPY: begin
            // Zero-page index wraps within the page; carry is dropped
            w_t_load_l = 1'b1;
            w_t_load_h = 1'b1;
            w_t_l_in   = w_sum[7:0];
            w_t_h_in   = ZP_PAGE;
            state_d    = S_DONE;
          end
          c_M_ABS, c_M_ABSX, c_M_ABSY: begin
            w_t_load_l = 1'b1;
            w_t_l_in   = w_sum[7:0];
            pcross_d   = w_sum[8];
            state_d    = S_OPHI;
          end
          c_M_INDY: begin
            ptr_d   = data_in;
            state_d = S_PLO;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_OPHI: begin
        w_pc_inc   = 1'b1;
        w_t_load_h = 1'b1;
        w_t_h_in   = data_in;
        state_d    = (pcross_q || w_store_fix) ? S_FIXUP : S_DONE;
      end
      S_PLO: begin
        w_addr_sel = 2'd2;
        w_t_load_l = 1'b1;
        w_t_l_in   = w_sum[7:0];
        pcross_d   = w_sum[8];
        // Pointer high byte is fetched from the same zero page, wrapping
        ptr_d      = ptr_q + 8'h01;
        state_d    = S_PHI;
      end
      S_PHI: begin
        w_addr_sel = 2'd2;
        w_t_load_h = 1'b1;
        w_t_h_in   = data_in;
        state_d    = (pcross_q || w_store_fix) ? S_FIXUP : S_DONE;
      end
      S_FIXUP: begin
        // Dummy read at the uncorrected address while the high byte is fixed
        w_addr_sel = 2'd1;
        w_t_h_inc  = pcross_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        w_addr_sel = 2'd1;
        w_done     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are forced low while reset is held
  assign pc_inc     = ~rst & w_pc_inc;
  assign t_load_l   = ~rst & w_t_load_l;
  assign t_load_h   = ~rst & w_t_load_h;
  assign t_h_inc    = ~rst & w_t_h_inc;
  assign t_l_in     = rst ? 8'h00 : w_t_l_in;
  assign t_h_in     = rst ? 8'h00 : w_t_h_in;
  assign addr_sel   = rst ? 2'd0 : w_addr_sel;
  assign ptr_out    = rst ? 8'h00 : ptr_q;
  assign busy       = ~rst & (state_q != S_IDLE);
  assign done       = ~rst & w_done;
  assign page_cross = ~rst & pcross_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_seq
// Description : Self-checking bench for addr_seq with PC/T register and
//               memory models; table vectors, corner sequences, random runs.
// Config      : honours ADDR_SEQ_STORE_FIXUP_EN for expected cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_seq;

  localparam logic [7:0] c_ZP = 8'h00;
`ifdef ADDR_SEQ_STORE_FIXUP_EN
  localparam bit c_STORE_FIX = 1'b1;
`else
  localparam bit c_STORE_FIX = 1'b0;
`endif

  typedef struct {
    logic [2:0]  mode;
    logic        st;
    logic [7:0]  x, y, b1, b2, lo, hi;
    logic [15:0] exp_t;
    int          exp_lat;
    logic        exp_pcx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, is_store;
  logic [2:0] mode;
  logic [7:0] x_in, y_in, data_in;
  logic       pc_inc, t_load_l, t_load_h, t_h_inc, busy, done, page_cross;
  logic [7:0] t_l_in, t_h_in, ptr_out;
  logic [1:0] addr_sel;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc, t, pc_set_val;
  logic        pc_set;
  logic [32:0] all_out;
  int          tests = 0, fails = 0, overlap = 0;

  addr_seq #(.ZP_PAGE(c_ZP)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .is_store(is_store),
    .x_in(x_in), .y_in(y_in), .data_in(data_in), .pc_inc(pc_inc),
    .t_load_l(t_load_l), .t_load_h(t_load_h), .t_h_inc(t_h_inc),
    .t_l_in(t_l_in), .t_h_in(t_h_in), .addr_sel(addr_sel), .ptr_out(ptr_out),
    .busy(busy), .done(done), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  // External PC and T registers driven by the sequencer strobes
  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_inc) pc <= pc + 16'd1;
    if (t_load_l) t[7:0] <= t_l_in;
    if (t_load_h) t[15:8] <= t_h_in;
    if (t_h_inc) t[15:8] <= t[15:8] + 8'd1;
  end

  // Zero-wait memory on the selected address source
  always_comb begin
    case (addr_sel)
      2'd0:    data_in = mem[pc];
      2'd1:    data_in = mem[t];
      2'd2:    data_in = mem[{c_ZP, ptr_out}];
      default: data_in = 8'h00;
    endcase
    all_out = {pc_inc, t_load_l, t_load_h, t_h_inc, t_l_in, t_h_in, addr_sel,
               ptr_out, busy, done, page_cross};
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: effective address, page cross, cycle count, PC advance
  function automatic void ref_model(input vec_t v, output logic [15:0] ea,
                                    output int lat, output logic pcx, output int npc);
    int idx, base, lowsum;
    bit fix;
    idx = (v.mode == 3'd1 || v.mode == 3'd4) ? int'(v.x) :
          (v.mode == 3'd2 || v.mode == 3'd5 || v.mode == 3'd6) ? int'(v.y) : 0;
    if (v.mode <= 3'd2) begin
      ea = {c_ZP, 8'((int'(v.b1) + idx) % 256)};
      lat = 2; pcx = 1'b0; npc = 1;
    end else begin
      base   = (v.mode == 3'd6) ? int'(v.hi) * 256 + int'(v.lo) : int'(v.b2) * 256 + int'(v.b1);
      lowsum = (base % 256) + idx;
      pcx    = (lowsum > 255);
      ea     = 16'((base + idx) % 65536);
      fix    = pcx || (c_STORE_FIX && v.st && v.mode != 3'd3);
      lat    = ((v.mode == 3'd6) ? 4 : 3) + (fix ? 1 : 0);
      npc    = (v.mode == 3'd6) ? 1 : 2;
    end
  endfunction

  task automatic run_seq(input vec_t v, input bit spam, output logic [15:0] got_t,
                         output int got_lat, output logic got_pcx, output int got_npc,
                         output int got_thinc, output logic [7:0] p0, output logic [7:0] p1);
    logic [15:0] pc0;
    bit acc;
    int np;
    pc0 = 16'h8000 + 16'($urandom_range(0, 16'h6FFF));
    mem[pc0] = v.b1;
    mem[pc0 + 16'd1] = v.b2;
    if (v.mode == 3'd6) begin
      mem[{c_ZP, v.b1}] = v.lo;
      mem[{c_ZP, 8'(v.b1 + 8'd1)}] = v.hi;
    end
    pc_set_val = pc0; pc_set = 1'b1;
    start = 1'b1; mode = v.mode; is_store = v.st; x_in = v.x; y_in = v.y;
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(posedge clk); #1;
      if (busy) acc = 1'b1;
    end
    pc_set = 1'b0;
    got_lat = -1; got_npc = 0; got_thinc = 0; np = 0; p0 = 8'h00; p1 = 8'h00;
    if (acc) begin
      if (!spam) start = 1'b0;
      for (int c = 1; c < 12; c++) begin
        if (spam) begin
          mode = 3'($urandom); x_in = 8'($urandom); y_in = 8'($urandom);
          is_store = 1'($urandom);
        end
        if (pc_inc) got_npc++;
        if (t_h_inc) got_thinc++;
        if (t_h_inc && (t_load_h || pc_inc)) overlap++;
        if (addr_sel == 2'd2) begin
          if (np == 0) p0 = ptr_out; else p1 = ptr_out;
          np++;
        end
        if (done) begin got_lat = c; break; end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    got_t = t;
    got_pcx = page_cross;
    got_npc = got_npc - int'(pc - pc0) + int'(pc - pc0);
    chk("pc_advance_vs_strobes", int'(pc - pc0), got_npc);
  endtask

  vec_t        tbl [9];
  vec_t        rv;
  logic [15:0] gt, et;
  int          gl, el, gn, en, gh;
  logic        gp, ep;
  logic [7:0]  p0, p1;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'd0; is_store = 1'b0; x_in = 8'h00; y_in = 8'h00;
    pc_set = 1'b0; pc_set_val = 16'h0000; pc = 16'h0000; t = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);

    tbl[0] = '{3'd4, 1'b0, 8'h10, 8'h00, 8'h20, 8'h30, 8'h00, 8'h00, 16'h3030, 3, 1'b0};
    tbl[1] = '{3'd5, 1'b0, 8'h00, 8'h01, 8'hFF, 8'h12, 8'h00, 8'h00, 16'h1300, 4, 1'b1};
    tbl[2] = '{3'd1, 1'b0, 8'h05, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, {c_ZP, 8'h03}, 2, 1'b0};
    tbl[3] = '{3'd6, 1'b0, 8'h00, 8'h20, 8'hFF, 8'h00, 8'hF0, 8'h40, 16'h4110, 5, 1'b1};
    tbl[4] = '{3'd4, 1'b1, 8'h01, 8'h00, 8'h10, 8'h22, 8'h00, 8'h00, 16'h2211,
               c_STORE_FIX ? 4 : 3, 1'b0};
    tbl[5] = '{3'd0, 1'b0, 8'h99, 8'h77, 8'h44, 8'h00, 8'h00, 8'h00, {c_ZP, 8'h44}, 2, 1'b0};
    tbl[6] = '{3'd3, 1'b1, 8'h55, 8'h66, 8'h34, 8'h12, 8'h00, 8'h00, 16'h1234, 3, 1'b0};
    tbl[7] = '{3'd2, 1'b0, 8'h00, 8'h80, 8'h90, 8'h00, 8'h00, 8'h00, {c_ZP, 8'h10}, 2, 1'b0};
    tbl[8] = '{3'd6, 1'b1, 8'h00, 8'h01, 8'h10, 8'h00, 8'h20, 8'h05, 16'h0521,
               c_STORE_FIX ? 5 : 4, 1'b0};

    // Power-on reset: every output low while rst is held
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_outputs", all_out, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_busy", busy, 0);

    // Directed table, back-to-back; rows 4 and 8 keep pulsing start while busy
    for (int i = 0; i < 9; i++) begin
      run_seq(tbl[i], (i == 4 || i == 8), gt, gl, gp, gn, gh, p0, p1);
      chk($sformatf("tbl%0d_t", i), gt, tbl[i].exp_t);
      chk($sformatf("tbl%0d_latency", i), gl, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_page_cross", i), gp, tbl[i].exp_pcx);
      chk($sformatf("tbl%0d_pc_inc_cycles", i), gn,
          (tbl[i].mode >= 3'd3 && tbl[i].mode <= 3'd5) ? 2 : 1);
      chk($sformatf("tbl%0d_t_h_inc_cycles", i), gh, tbl[i].exp_pcx ? 1 : 0);
      if (tbl[i].mode == 3'd6) begin
        chk($sformatf("tbl%0d_ptr_first", i), p0, tbl[i].b1);
        chk($sformatf("tbl%0d_ptr_second", i), p1, 8'(tbl[i].b1 + 8'd1));
      end
    end

    // Reserved mode is ignored
    @(posedge clk); #1;
    start = 1'b1; mode = 3'd7;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mode7_ignored_busy", busy, 0);
    end
    start = 1'b0;

    // Reset asserted for two cycles in OPHI after a page-crossing low byte
    mem[16'h9000] = 8'hFF; mem[16'h9001] = 8'h12;
    pc_set_val = 16'h9000; pc_set = 1'b1;
    start = 1'b1; mode = 3'd5; is_store = 1'b0; y_in = 8'h01;
    @(posedge clk); #1;
    pc_set = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("ophi_page_cross_set", page_cross, 1);
    chk("ophi_pc_inc", pc_inc, 1);
    rst = 1'b1; #1;
    chk("rst_mid_outputs_comb", all_out, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_mid_outputs", all_out, 0);
    end
    rst = 1'b0; #1;
    chk("rst_release_idle", all_out, 0);
    @(posedge clk); #1;
    chk("rst_release_stays_idle", busy, 0);

    // Randomized runs against the reference model
    for (int n = 0; n < 40; n++) begin
      rv.mode = 3'($urandom_range(0, 6)); rv.st = 1'($urandom);
      rv.x = 8'($urandom); rv.y = 8'($urandom); rv.b1 = 8'($urandom);
      rv.b2 = 8'($urandom); rv.lo = 8'($urandom); rv.hi = 8'($urandom);
      rv.exp_t = 16'h0; rv.exp_lat = 0; rv.exp_pcx = 1'b0;
      ref_model(rv, et, el, ep, en);
      run_seq(rv, 1'($urandom), gt, gl, gp, gn, gh, p0, p1);
      chk($sformatf("rnd%0d_m%0d_t", n, rv.mode), gt, et);
      chk($sformatf("rnd%0d_latency", n), gl, el);
      chk($sformatf("rnd%0d_page_cross", n), gp, ep);
      chk($sformatf("rnd%0d_pc_inc_cycles", n), gn, en);
      chk($sformatf("rnd%0d_t_h_inc_cycles", n), gh, ep ? 1 : 0);
    end

    chk("strobe_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
